root_hub_router: RTL and testbench
==================================

# root_hub_router

Synthesizable N-channel flit router for the root hub of the multi-FPGA decoder tree. It is the parametrised successor of the fixed five-port root hub core. Channel 0 is the local controller link, and channels 1..NUM_CHANNELS-1 are leaf FPGA links. Each 64-bit flit is routed by its destination field to one output, or broadcast to all outputs except the source. Each output has a round-robin arbiter and a registered output stage.

## Interface
- NUM_CHANNELS, 5, number of bidirectional channels (2..16); channel index equals FPGA ID.
- CHANNEL_WIDTH, 64, flit width in bits.
- DEST_WIDTH, 8, width of destination field, located at flit[CHANNEL_WIDTH-1 -: DEST_WIDTH].
- BROADCAST_ID, 8'hFF, destination value meaning "all channels except source".
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- rx_data  input  NUM_CHANNELS*CHANNEL_WIDTH  incoming flits, channel i at [CHANNEL_WIDTH*i +: CHANNEL_WIDTH].
- rx_valid  input  NUM_CHANNELS  incoming flit valid per channel.
- rx_ready  output  NUM_CHANNELS  flit consumed this cycle (combinational).
- tx_data  output  NUM_CHANNELS*CHANNEL_WIDTH  outgoing flits, same packing.
- tx_valid  output  NUM_CHANNELS  outgoing flit valid (registered).
- tx_ready  input  NUM_CHANNELS  downstream accepts flit.
- drop_count  output  16  saturating count of flits dropped for an invalid destination.

## Operation
- Handshake rule: a transfer occurs on a rising edge where valid && ready. Sources hold data and valid stable until ready. The router never retracts tx_valid or changes tx_data while tx_ready is low.
- Decode per input i: dest < NUM_CHANNELS gives target mask 1<<dest, with loopback (dest==i) allowed. dest==BROADCAST_ID gives all ones & ~(1<<i). Any other value is invalid.
- Per-input register done_i[NUM_CHANNELS] holds the outputs already served for the current flit. req_i = rx_valid[i] ? (target_i & ~done_i) : 0.
- Output j is free when !tx_valid[j] || tx_ready[j].
- Per-output round-robin arbiter: among inputs with req_i[j], grant the first at or after ptr_j, wrapping around. A grant is issued only when output j is free. On a grant, ptr_j <= winner+1 mod NUM_CHANNELS, and the output register loads rx_data[winner] with tx_valid[j] <= 1.
- If output j is free and has no grant, tx_valid[j] <= 0. tx_data holds its last value.
- Consumption: rx_ready[i]=1 when rx_valid[i] and (target_i & ~done_i & ~grant_i) == 0, where grant_i is the set of outputs granting i this cycle. On consumption, done_i <= 0; otherwise done_i <= done_i | grant_i.
- Broadcast is non-atomic. Copies may leave on different cycles, each output in its own arbitration order. Exactly one copy reaches each target.
- Invalid destination: rx_ready[i]=1 immediately with no output traffic, and drop_count increments, saturating at 16'hFFFF.
- Broadcast with NUM_CHANNELS==2 from a channel with no other target is not a drop: the target mask is non-empty since 2 channels exist. The single-channel case is excluded by the parameter range.

## Timing
- Reset asserted: tx_valid=0, tx_data=0, rx_ready=0, drop_count=0, all ptr_j=0, all done_i=0, regardless of clk.
- Reset release: first grants are possible on the first rising edge after reset reads 1.
- Latency: a flit accepted on edge k appears on tx on cycle k+1, so unicast valid-to-valid is 1 cycle. Throughput is 1 flit/cycle/output.
- Simultaneous events: one output can pop (tx_ready) and load a new flit on the same edge, with no bubble. One input can be granted by several outputs in one cycle.
- Reset mid-broadcast: done_i clears, so after release the still-valid flit is re-sent to all targets.

## Test plan
- Unicast: rx 0 sends dest=2, data 64'h02_00..0ABC, all tx_ready=1 -> tx_valid[2]=1 next cycle with identical data; other tx_valid=0; rx_ready[0]=1 in the same cycle.
- Contention: inputs 1, 3 and 4 hold dest=0 continuously, ptr_0=0 -> output 0 serves the order 1,3,4,1 on consecutive cycles; each input's rx_ready pulses once per 3 cycles.
- Backpressure: tx_ready[2]=0 for 5 cycles with input 1 sending dest=2 -> tx_data[2] stable, rx_ready[1]=0 after the first flit; the second flit appears the cycle after tx_ready[2] rises.
- Broadcast partial stall: NUM_CHANNELS=5, input 0 sends dest=FF, tx_ready[3]=0 for 4 cycles -> outputs 1, 2 and 4 receive one copy each immediately; output 3 gets exactly one copy after the stall; rx_ready[0] is high only in the final-grant cycle.
- Invalid dest: input 2 sends dest=8'h07 three times -> no tx_valid, drop_count=3; preload 16'hFFFF -> stays at FFFF.
- Reset mid-broadcast: assert reset after 2 of 4 copies -> tx_valid=0 asynchronously; after release, all 4 targets receive the flit.

Source files
------------

// File: rtl/root_hub_router.sv
// Root hub flit router: destination/broadcast decode, per-output round-robin arbitration,
// registered output stage and a saturating counter of flits dropped for bad destinations.
module root_hub_router #(
  parameter int                    NUM_CHANNELS  = 5,
  parameter int                    CHANNEL_WIDTH = 64,
  parameter int                    DEST_WIDTH    = 8,
  parameter logic [DEST_WIDTH-1:0] BROADCAST_ID  = 8'hFF
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] rx_data_i,
  input  logic [NUM_CHANNELS-1:0]               rx_valid_i,
  output logic [NUM_CHANNELS-1:0]               rx_ready_o,
  output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] tx_data_o,
  output logic [NUM_CHANNELS-1:0]               tx_valid_o,
  input  logic [NUM_CHANNELS-1:0]               tx_ready_i,
  output logic [15:0]                           drop_count_o
);

  localparam int N  = NUM_CHANNELS;
  localparam int W  = CHANNEL_WIDTH;
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef logic [N-1:0] mask_t;

  logic [DEST_WIDTH-1:0] dest      [N];
  mask_t                 target    [N];
  mask_t                 req       [N];
  mask_t                 grant_in  [N];
  mask_t                 done_q    [N];
  mask_t                 done_d    [N];
  logic [N-1:0]          bad;

  logic [PW-1:0]         ptr_q     [N];
  logic [PW-1:0]         ptr_d     [N];
  logic [PW-1:0]         win_idx   [N];
  logic [N-1:0]          win_vld;
  logic [N-1:0]          out_free;
  logic [N-1:0]          out_grant;

  logic [W-1:0]          tx_data_q [N];
  logic [W-1:0]          tx_data_d [N];
  logic [N-1:0]          tx_valid_q;
  logic [N-1:0]          tx_valid_d;

  logic [15:0]           drop_q;
  logic [15:0]           drop_d;
  logic [CW-1:0]         ndrop;
  logic [16:0]           drop_sum;

  for (genvar g = 0; g < N; g++) begin : g_chan
    assign dest[g]              = rx_data_i[W*g + W - 1 -: DEST_WIDTH];
    assign tx_data_o[W*g +: W]  = tx_data_q[g];
  end

  // Target decode; a zero target mask marks an invalid destination.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      target[i] = '0;
      bad[i]    = 1'b0;
      if (dest[i] == BROADCAST_ID) begin
        target[i]    = '1;
        target[i][i] = 1'b0;
      end else if (int'(dest[i]) < N) begin
        for (int j = 0; j < N; j++) begin
          target[i][j] = (int'(dest[i]) == j);
        end
      end else begin
        bad[i] = 1'b1;
      end
      req[i] = rx_valid_i[i] ? (target[i] & ~done_q[i]) : '0;
    end
  end

  // Round-robin search starting at ptr_q, wrapping around.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      win_vld[j] = 1'b0;
      win_idx[j] = '0;
      for (int k = 0; k < N; k++) begin
        if (!win_vld[j] && req[(int'(ptr_q[j]) + k) % N][j]) begin
          win_vld[j] = 1'b1;
          win_idx[j] = PW'((int'(ptr_q[j]) + k) % N);
        end
      end
      out_free[j]  = !tx_valid_q[j] || tx_ready_i[j];
      out_grant[j] = out_free[j] && win_vld[j];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        grant_in[i][j] = out_grant[j] && (win_idx[j] == PW'(i));
      end
      rx_ready_o[i] = rst_ni && rx_valid_i[i] &&
                      ((target[i] & ~done_q[i] & ~grant_in[i]) == '0);
      done_d[i]     = rx_ready_o[i] ? '0 : (done_q[i] | grant_in[i]);
    end
  end

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < N; i++) begin
      ndrop = ndrop + CW'(rx_ready_o[i] && bad[i]);
    end
    drop_sum = {1'b0, drop_q} + 17'(ndrop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Output stage: a free output either loads the winner or goes idle; tx_data is held.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      tx_data_d[j]  = tx_data_q[j];
      tx_valid_d[j] = tx_valid_q[j];
      ptr_d[j]      = ptr_q[j];
      if (out_grant[j]) begin
        tx_data_d[j]  = rx_data_i[W*int'(win_idx[j]) +: W];
        tx_valid_d[j] = 1'b1;
        ptr_d[j]      = (int'(win_idx[j]) == N - 1) ? '0 : win_idx[j] + PW'(1);
      end else if (out_free[j]) begin
        tx_valid_d[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        done_q[i]    <= '0;
        ptr_q[i]     <= '0;
        tx_data_q[i] <= '0;
      end
      tx_valid_q <= '0;
      drop_q     <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        done_q[i]    <= done_d[i];
        ptr_q[i]     <= ptr_d[i];
        tx_data_q[i] <= tx_data_d[i];
      end
      tx_valid_q <= tx_valid_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_valid_o   = tx_valid_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_root_hub_router.sv
// Bench for root_hub_router: directed timing/arbitration checks plus randomized traffic
// checked by a per-(source,output) scoreboard fed from the routing rules.
module tb_root_hub_router;

  localparam int N = 5;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] rx_data;
  logic [N-1:0]   rx_valid;
  logic [N-1:0]   rx_ready;
  logic [N*W-1:0] tx_data;
  logic [N-1:0]   tx_valid;
  logic [N-1:0]   tx_ready;
  logic [15:0]    drop_count;

  root_hub_router #(
    .NUM_CHANNELS (N),
    .CHANNEL_WIDTH(W),
    .DEST_WIDTH   (8),
    .BROADCAST_ID (8'hFF)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .drop_count_o(drop_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef logic [W-1:0] flit_t;
  flit_t        expq [N*N][$];
  bit           sb_en = 1'b0;
  logic [N-1:0] stall_q = '0;
  flit_t        hold_q [N];
  flit_t        mon_d;
  flit_t        mon_e;
  int           mon_src;
  int           drops_exp = 0;
  int           seq = 0;
  logic [N-1:0] cons = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic flit_t txd(input int j);
    return tx_data[W*j +: W];
  endfunction

  task automatic put(input int i, input logic [7:0] d, input logic [55:0] body);
    rx_data[W*i +: W] = {d, body};
    rx_valid[i]       = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic flit_t cflit(input int i);
    return {8'h00, 48'hC0_0000_0000, 8'(i)};
  endfunction

  // Random flit: expected copies go straight to the scoreboard from the routing rules.
  task automatic issue(input int i);
    int          r;
    logic [7:0]  d;
    flit_t       f;
    r = $urandom_range(0, 9);
    if (r < 6)      d = 8'($urandom_range(0, N - 1));
    else if (r < 8) d = 8'hFF;
    else            d = 8'($urandom_range(N, 254));
    f = {d, 24'($urandom), 16'(seq), 4'h0, 4'(i), 8'($urandom)};
    seq++;
    rx_data[W*i +: W] = f;
    rx_valid[i]       = 1'b1;
    if (d == 8'hFF) begin
      for (int j = 0; j < N; j++) if (j != i) expq[i*N + j].push_back(f);
    end else if (int'(d) < N) begin
      expq[i*N + int'(d)].push_back(f);
    end else begin
      drops_exp++;
    end
  endtask

  // Monitor: every output transfer must match the oldest outstanding copy from its source.
  always @(negedge clk) begin
    if (sb_en) begin
      for (int j = 0; j < N; j++) begin
        if (stall_q[j]) begin
          tests++;
          if (!(tx_valid[j] && txd(j) == hold_q[j])) begin
            fails++;
            $display("FAIL tx_hold[%0d]: got valid=%0b data=%0h required valid=1 data=%0h",
                     j, tx_valid[j], txd(j), hold_q[j]);
          end
        end
        if (tx_valid[j] && tx_ready[j]) begin
          mon_d   = txd(j);
          mon_src = int'(mon_d[11:8]);
          tests++;
          if (mon_src >= N || expq[mon_src*N + j].size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected[%0d]: got %0h required no flit", j, mon_d);
          end else begin
            mon_e = expq[mon_src*N + j].pop_front();
            if (mon_d !== mon_e) begin
              fails++;
              $display("FAIL sb_data[%0d]: got %0h required %0h", j, mon_d, mon_e);
            end
          end
        end
        stall_q[j] = tx_valid[j] && !tx_ready[j];
        hold_q[j]  = txd(j);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         order [6] = '{1, 3, 4, 1, 3, 4};
    flit_t      fa, fb, fbc, ff;
    bit         drained;
    int         pending;
    int         dexp;

    rst_n    = 1'b0;
    rx_valid = '0;
    rx_data  = '0;
    tx_ready = '1;
    put(2, 8'h07, 56'h1);
    #3;
    chk("rst_tx_valid", 64'(tx_valid), 0);
    chk("rst_rx_ready", 64'(rx_ready), 0);
    chk("rst_drop", 64'(drop_count), 0);
    chk("rst_tx_data", 64'(tx_data != '0), 0);
    rx_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Unicast
    put(0, 8'h02, 56'h0ABC);
    mid();
    chk("uni_rx_ready", 64'(rx_ready), 64'b00001);
    chk("uni_tx_pre", 64'(tx_valid), 0);
    tick();
    rx_valid[0] = 1'b0;
    mid();
    chk("uni_tx_valid", 64'(tx_valid), 64'b00100);
    chk("uni_tx_data", txd(2), 64'h0200_0000_0000_0ABC);
    tick();
    mid();
    chk("uni_tx_idle", 64'(tx_valid), 0);

    // Contention on output 0
    tick();
    put(1, 8'h00, cflit(1)[55:0]);
    put(3, 8'h00, cflit(3)[55:0]);
    put(4, 8'h00, cflit(4)[55:0]);
    for (int c = 0; c < 6; c++) begin
      mid();
      chk("arb_rx_ready", 64'(rx_ready), 64'(1 << order[c]));
      if (c > 0) chk("arb_tx_src", txd(0), cflit(order[c-1]));
      tick();
    end
    rx_valid = '0;
    mid();
    chk("arb_tx_last", txd(0), cflit(4));
    chk("arb_tx_valid", 64'(tx_valid), 64'b00001);

    // Backpressure on output 2
    fa = 64'h0211_1111_1111_1111;
    fb = 64'h0222_2222_2222_2222;
    tick();
    tx_ready = 5'b11011;
    put(1, fa[63:56], fa[55:0]);
    mid();
    chk("bp_first_ready", 64'(rx_ready), 64'b00010);
    tick();
    put(1, fb[63:56], fb[55:0]);
    for (int c = 0; c < 5; c++) begin
      mid();
      chk("bp_stall_ready", 64'(rx_ready), 0);
      chk("bp_hold_valid", 64'(tx_valid[2]), 1);
      chk("bp_hold_data", txd(2), fa);
      tick();
    end
    tx_ready = '1;
    mid();
    chk("bp_release_ready", 64'(rx_ready), 64'b00010);
    tick();
    rx_valid = '0;
    mid();
    chk("bp_second_valid", 64'(tx_valid), 64'b00100);
    chk("bp_second_data", txd(2), fb);
    tick();
    mid();
    chk("bp_idle", 64'(tx_valid), 0);

    // Broadcast with output 3 held busy by a stalled flit
    ff  = 64'h03F0_F0F0_F0F0_F0F0;
    fbc = 64'hFFBC_BCBC_BCBC_BC00;
    tick();
    tx_ready = 5'b10111;
    put(4, ff[63:56], ff[55:0]);
    mid();
    chk("bc_pre_ready", 64'(rx_ready), 64'b10000);
    tick();
    rx_valid[4] = 1'b0;
    put(0, fbc[63:56], fbc[55:0]);
    mid();
    chk("bc_partial_ready", 64'(rx_ready), 0);
    tick();
    mid();
    chk("bc_copies", 64'(tx_valid), 64'b11110);
    chk("bc_data1", txd(1), fbc);
    chk("bc_data2", txd(2), fbc);
    chk("bc_data4", txd(4), fbc);
    chk("bc_data3_held", txd(3), ff);
    chk("bc_wait_ready", 64'(rx_ready), 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      mid();
      chk("bc_wait_valid", 64'(tx_valid), 64'b01000);
      chk("bc_wait_ready", 64'(rx_ready), 0);
    end
    tick();
    tx_ready = '1;
    mid();
    chk("bc_final_ready", 64'(rx_ready), 64'b00001);
    tick();
    rx_valid[0] = 1'b0;
    mid();
    chk("bc_late_valid", 64'(tx_valid), 64'b01000);
    chk("bc_late_data", txd(3), fbc);
    tick();
    mid();
    chk("bc_idle", 64'(tx_valid), 0);

    // Invalid destination
    for (int c = 0; c < 3; c++) begin
      tick();
      put(2, 8'h07, 56'(c));
      mid();
      chk("inv_ready", 64'(rx_ready), 64'b00100);
      chk("inv_no_tx", 64'(tx_valid), 0);
    end
    tick();
    rx_valid = '0;
    mid();
    chk("inv_no_tx_end", 64'(tx_valid), 0);
    chk("inv_drop3", 64'(drop_count), 3);

    // Reset in the middle of a broadcast
    fbc = 64'hFF5A_5A5A_5A5A_5A01;
    tick();
    tx_ready = 5'b00111;
    put(0, 8'h03, 56'hD0);
    put(2, 8'h04, 56'hD2);
    mid();
    chk("rm_pre_ready", 64'(rx_ready), 64'b00101);
    tick();
    rx_valid = '0;
    put(1, fbc[63:56], fbc[55:0]);
    mid();
    chk("rm_partial_ready", 64'(rx_ready), 0);
    tick();
    chk("rm_two_copies", 64'(tx_valid), 64'b11101);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_rst_valid", 64'(tx_valid), 0);
    chk("rm_rst_ready", 64'(rx_ready), 0);
    chk("rm_rst_data", 64'(tx_data != '0), 0);
    chk("rm_rst_drop", 64'(drop_count), 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    tx_ready = '1;
    mid();
    chk("rm_resend_ready", 64'(rx_ready), 64'b00010);
    tick();
    rx_valid = '0;
    mid();
    chk("rm_resend_valid", 64'(tx_valid), 64'b11101);
    chk("rm_resend_d0", txd(0), fbc);
    chk("rm_resend_d2", txd(2), fbc);
    chk("rm_resend_d3", txd(3), fbc);
    chk("rm_resend_d4", txd(4), fbc);
    tick();
    mid();
    chk("rm_idle", 64'(tx_valid), 0);

    // Randomized traffic against the scoreboard
    sb_en = 1'b1;
    cons  = '0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!rx_valid[i] || cons[i]) begin
          if ($urandom_range(0, 9) < 7) issue(i);
          else rx_valid[i] = 1'b0;
        end
      end
      tx_ready = N'($urandom) | N'($urandom);
      mid();
      cons = rx_valid & rx_ready;
    end
    drained = 1'b0;
    for (int c = 0; c < 300 && !drained; c++) begin
      tick();
      for (int i = 0; i < N; i++) if (cons[i]) rx_valid[i] = 1'b0;
      tx_ready = '1;
      mid();
      cons = rx_valid & rx_ready;
      if (rx_valid == '0 && tx_valid == '0) drained = 1'b1;
    end
    sb_en = 1'b0;
    chk("rand_drained", 64'(drained), 1);
    pending = 0;
    for (int k = 0; k < N*N; k++) pending += expq[k].size();
    chk("rand_missing_copies", 64'(pending), 0);
    chk("rand_drop_count", 64'(drop_count), 64'(drops_exp));

    // Drive every input with a bad destination until the drop counter saturates
    dexp = drops_exp;
    tick();
    for (int i = 0; i < N; i++) put(i, 8'h80, 56'(i));
    mid();
    chk("sat_all_ready", 64'(rx_ready), 64'b11111);
    for (int c = 0; c < 13200; c++) begin
      tick();
      dexp = (dexp + N > 65535) ? 65535 : dexp + N;
      if (c % 2048 == 0) begin
        mid();
        chk("sat_progress", 64'(drop_count), 64'(dexp));
      end
    end
    mid();
    chk("sat_value", 64'(drop_count), 64'hFFFF);
    for (int c = 0; c < 3; c++) tick();
    mid();
    chk("sat_hold", 64'(drop_count), 64'hFFFF);
    chk("sat_no_tx", 64'(tx_valid), 0);
    rx_valid = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
